systolic_feeder: RTL and testbench

- Operand feeder for the 4x4 systolic array; the producing end of the array's activation input.
- Accepts one activation tile, one row per beat, over a valid/ready stream and buffers it.
- Replays the tile into the array's input lanes as a skewed diagonal wavefront, with per-lane valid, first/last markers and an accumulator-clear pulse.

---
 rtl/systolic_feeder.sv | 190 +++++++++++++++++++
 tb/tb_systolic_feeder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers a 4x4 activation tile, one row per beat, and
// replays it into the array lanes as a skewed diagonal wavefront.
// Optional build macro SYSTOLIC_FEEDER_PINGPONG_EN selects two tile banks
// so a tile can fill while the previous one drains. Without it a single
// bank is used and the input stalls for the whole drain.
module systolic_feeder #(
    parameter int unsigned N      = 4,
    parameter int unsigned DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N*DATA_W-1:0]   in_data,
    input  logic                  arr_ready,
    output logic [N*DATA_W-1:0]   arr_data,
    output logic [N-1:0]          arr_valid,
    output logic                  arr_first,
    output logic                  arr_last,
    output logic                  acc_clr,
    output logic                  busy
);

`ifdef SYSTOLIC_FEEDER_PINGPONG_EN
    localparam int unsigned NB = 2;
`else
    localparam int unsigned NB = 1;
`endif
    localparam int unsigned LAST_T = 2 * N - 2;
    localparam int unsigned T_W    = (LAST_T > 0) ? $clog2(LAST_T + 1) : 1;
    localparam int unsigned R_W    = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned ROW_W  = N * DATA_W;

    typedef enum logic {FILL, DRAIN} state_e;

    state_e             state_q, state_d;
    logic [T_W-1:0]     t_q, t_d;
    logic [R_W-1:0]     wr_row_q, wr_row_d;
    logic               fill_bank_q, fill_bank_d;
    logic               drain_bank_q, drain_bank_d;
    logic [NB-1:0]      full_q, full_d;
    logic [ROW_W-1:0]   buf_q [NB][N];
    logic [ROW_W-1:0]   arr_data_q, arr_data_d;
    logic [N-1:0]       arr_valid_q, arr_valid_d;
    logic               arr_first_q, arr_first_d;
    logic               arr_last_q, arr_last_d;
    logic               acc_clr_q, acc_clr_d;
    logic               busy_q, busy_d;

    logic               accept, fill_done, finishing, start, nb, cand_full;
    logic               do_load, ld_bank;
    logic [T_W-1:0]     ld_t;
    logic [ROW_W-1:0]   row_w;
    int                 row_i;

    // Bank after b; a single-bank build always stays on bank 0.
    function automatic logic flip(input logic b);
        return (NB > 1) ? ~b : 1'b0;
    endfunction

    // A bank that holds an unsent tile cannot be refilled.
    assign in_ready  = !rst && !full_q[fill_bank_q];
    assign accept    = in_valid && in_ready;
    assign fill_done = accept && (wr_row_q == R_W'(N - 1));

    assign arr_data  = arr_data_q;
    assign arr_valid = arr_valid_q;
    assign arr_first = arr_first_q;
    assign arr_last  = arr_last_q;
    assign acc_clr   = acc_clr_q;
    assign busy      = busy_q;

    // Fill bookkeeping, drain sequencing and next wavefront step.
    always_comb begin
        state_d      = state_q;
        t_d          = t_q;
        wr_row_d     = wr_row_q;
        fill_bank_d  = fill_bank_q;
        drain_bank_d = drain_bank_q;
        full_d       = full_q;
        arr_data_d   = arr_data_q;
        arr_valid_d  = arr_valid_q;
        arr_first_d  = arr_first_q;
        arr_last_d   = arr_last_q;
        acc_clr_d    = 1'b0;
        busy_d       = busy_q;
        do_load      = 1'b0;
        ld_t         = '0;
        ld_bank      = drain_bank_q;
        row_w        = '0;
        row_i        = 0;

        finishing = (state_q == DRAIN) && arr_ready && (t_q == T_W'(LAST_T));
        nb        = finishing ? flip(drain_bank_q) : drain_bank_q;
        cand_full = full_q[nb] && !(finishing && (nb == drain_bank_q));
        start     = ((state_q == FILL) || finishing) &&
                    (cand_full || (fill_done && (fill_bank_q == nb)));

        if (finishing) begin
            full_d[drain_bank_q] = 1'b0;
            drain_bank_d         = nb;
        end
        if (accept) begin
            wr_row_d = fill_done ? '0 : R_W'(wr_row_q + 1'b1);
            if (fill_done) begin
                full_d[fill_bank_q] = 1'b1;
                fill_bank_d         = flip(fill_bank_q);
            end
        end

        if (start) begin
            state_d   = DRAIN;
            t_d       = '0;
            do_load   = 1'b1;
            ld_t      = '0;
            ld_bank   = nb;
            acc_clr_d = 1'b1;
            busy_d    = 1'b1;
        end else if (finishing) begin
            state_d     = FILL;
            t_d         = '0;
            arr_data_d  = '0;
            arr_valid_d = '0;
            arr_first_d = 1'b0;
            arr_last_d  = 1'b0;
            busy_d      = 1'b0;
        end else if ((state_q == DRAIN) && arr_ready) begin
            t_d     = T_W'(t_q + 1'b1);
            do_load = 1'b1;
            ld_t    = T_W'(t_q + 1'b1);
            ld_bank = drain_bank_q;
        end

        // Lane k carries column k of row t-k; rows arriving this cycle bypass the buffer.
        if (do_load) begin
            arr_first_d = (ld_t == '0);
            arr_last_d  = (ld_t == T_W'(LAST_T));
            for (int k = 0; k < int'(N); k++) begin
                row_i = int'(ld_t) - k;
                if (row_i >= 0 && row_i < int'(N)) begin
                    row_w = buf_q[ld_bank][R_W'(row_i)];
                    if (accept && (fill_bank_q == ld_bank) && (wr_row_q == R_W'(row_i)))
                        row_w = in_data;
                    arr_valid_d[k]                 = 1'b1;
                    arr_data_d[k*DATA_W +: DATA_W] = row_w[k*DATA_W +: DATA_W];
                end else begin
                    arr_valid_d[k]                 = 1'b0;
                    arr_data_d[k*DATA_W +: DATA_W] = '0;
                end
            end
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FILL;
            t_q          <= '0;
            wr_row_q     <= '0;
            fill_bank_q  <= 1'b0;
            drain_bank_q <= 1'b0;
            full_q       <= '0;
            arr_data_q   <= '0;
            arr_valid_q  <= '0;
            arr_first_q  <= 1'b0;
            arr_last_q   <= 1'b0;
            acc_clr_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            t_q          <= t_d;
            wr_row_q     <= wr_row_d;
            fill_bank_q  <= fill_bank_d;
            drain_bank_q <= drain_bank_d;
            full_q       <= full_d;
            arr_data_q   <= arr_data_d;
            arr_valid_q  <= arr_valid_d;
            arr_first_q  <= arr_first_d;
            arr_last_q   <= arr_last_d;
            acc_clr_q    <= acc_clr_d;
            busy_q       <= busy_d;
        end
    end

    // Tile storage; contents are only meaningful once the bank is marked full.
    always_ff @(posedge clk) begin
        if (accept) buf_q[fill_bank_q][wr_row_q] <= in_data;
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed self-checking bench for systolic_feeder (N=4, DATA_W=16).
module tb_systolic_feeder;

`ifdef SYSTOLIC_FEEDER_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    logic        clk, rst, in_valid, in_ready, arr_ready;
    logic [63:0] in_data, arr_data;
    logic [3:0]  arr_valid;
    logic        arr_first, arr_last, acc_clr, busy;

    int vectors  = 0;
    int miscmp   = 0;
    int clr_seen = 0;

    // Hand-computed wavefront for tile {1..16}: lane values and valid masks per step.
    int tab [7][4] = '{'{1,0,0,0}, '{5,2,0,0}, '{9,6,3,0}, '{13,10,7,4},
                       '{0,14,11,8}, '{0,0,15,12}, '{0,0,0,16}};
    logic [3:0] vtab [7] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                             4'b1110, 4'b1100, 4'b1000};

    systolic_feeder #(.N(4), .DATA_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .arr_ready(arr_ready), .arr_data(arr_data),
        .arr_valid(arr_valid), .arr_first(arr_first), .arr_last(arr_last),
        .acc_clr(acc_clr), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
        vectors++;
        assert (obs === req) else begin
            miscmp++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, req);
        end
    endtask

    function automatic logic [63:0] row4(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic logic [63:0] exp_data(input int t, input bit sevens);
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < 4; k++)
            if (vtab[t][k]) v[k*16 +: 16] = sevens ? 16'd7 : 16'(tab[t][k]);
        return v;
    endfunction

    // Feeds four rows of the 1..16 tile (or all 7s); gappy drops in_valid between rows.
    task automatic feed(input bit sevens, input bit gappy);
        for (int r = 0; r < 4; r++) begin
            in_valid = 1'b1;
            in_data  = sevens ? row4(7,7,7,7) : row4(4*r+1, 4*r+2, 4*r+3, 4*r+4);
            @(posedge clk); #1;
            if (gappy && r < 3) begin
                in_valid = 1'b0;
                in_data  = row4(16'hdead, 16'hdead, 16'hdead, 16'hdead);
                chk("gap_no_drain", 64'(busy), 64'd0);
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
    endtask

    // Checks all seven steps, starting with step 0 already presented.
    task automatic check_drain(input bit sevens, input int stall_at, input int stall_len);
        for (int t = 0; t < 7; t++) begin
            chk($sformatf("data_s%0d", t),  arr_data, exp_data(t, sevens));
            chk($sformatf("valid_s%0d", t), 64'(arr_valid), 64'(vtab[t]));
            chk($sformatf("first_s%0d", t), 64'(arr_first), 64'(t == 0));
            chk($sformatf("last_s%0d", t),  64'(arr_last), 64'(t == 6));
            chk($sformatf("clr_s%0d", t),   64'(acc_clr), 64'(t == 0));
            chk($sformatf("busy_s%0d", t),  64'(busy), 64'd1);
            chk($sformatf("inrdy_s%0d", t), 64'(in_ready), 64'(PP));
            if (t == stall_at) begin
                arr_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    @(posedge clk); #1;
                    chk("stall_data", arr_data, exp_data(t, sevens));
                    chk("stall_valid", 64'(arr_valid), 64'(vtab[t]));
                    chk("stall_clr", 64'(acc_clr), 64'd0);
                end
                arr_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
        chk("end_valid", 64'(arr_valid), 64'd0);
        chk("end_data", arr_data, 64'd0);
        chk("end_last", 64'(arr_last), 64'd0);
        chk("end_busy", 64'(busy), 64'd0);
        chk("end_inrdy", 64'(in_ready), 64'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; arr_ready = 1'b1;
        #3;
        chk("rst_valid", 64'(arr_valid), 64'd0);
        chk("rst_data", arr_data, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_clr", 64'(acc_clr), 64'd0);
        chk("rst_inrdy", 64'(in_ready), 64'd0);
        #20;
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_inrdy", 64'(in_ready), 64'd1);

        // Basic wavefront.
        feed(1'b0, 1'b0);
        check_drain(1'b0, -1, 0);

        // Stall of three cycles at step 3.
        feed(1'b0, 1'b0);
        check_drain(1'b0, 3, 3);

        if (!PP) begin
            // Upstream keeps offering 99s during the drain; none may be taken.
            feed(1'b0, 1'b0);
            in_valid = 1'b1;
            in_data  = row4(99, 99, 99, 99);
            check_drain(1'b0, -1, 0);
        end

        // Gappy input; its row 0 is the first beat after the previous drain.
        feed(1'b0, 1'b1);
        check_drain(1'b0, -1, 0);

        // Reset at step 2, then a tile of 7s.
        feed(1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_valid", 64'(arr_valid), 64'(vtab[2]));
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(arr_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_inrdy", 64'(in_ready), 64'd0);
        chk("mid_rst_data", arr_data, 64'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        feed(1'b1, 1'b0);
        check_drain(1'b1, -1, 0);

        if (PP) begin
            // Two tiles back to back: tile 1..16 then 7s, continuous in_valid.
            for (int c = 0; c < 19; c++) begin
                if (c < 8) begin
                    in_valid = 1'b1;
                    in_data  = (c < 4) ? row4(4*c+1, 4*c+2, 4*c+3, 4*c+4) : row4(7,7,7,7);
                end else begin
                    in_valid = 1'b0;
                end
                @(posedge clk); #1;
                if (acc_clr) clr_seen++;
                if (c >= 3 && c <= 6) chk("pp_inrdy", 64'(in_ready), 64'd1);
                if (c >= 3 && c <= 9) begin
                    chk("pp_t1_data", arr_data, exp_data(c - 3, 1'b0));
                    chk("pp_t1_valid", 64'(arr_valid), 64'(vtab[c-3]));
                end else if (c >= 10 && c <= 16) begin
                    chk("pp_t2_data", arr_data, exp_data(c - 10, 1'b1));
                    chk("pp_t2_valid", 64'(arr_valid), 64'(vtab[c-10]));
                    chk("pp_t2_first", 64'(arr_first), 64'(c == 10));
                end else begin
                    chk("pp_idle_valid", 64'(arr_valid), 64'd0);
                end
            end
            chk("pp_clr_count", 64'(clr_seen), 64'd2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
        $finish;
    end

endmodule
